rr_reg_arbiter: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_reg_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rr_reg_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// rr_arb_pkg
// Shared types and width helpers for the round-robin register arbiter.
//   state_t : FSM encoding (IDLE, WRITE, HOLD)
//   HOLD_W  : width of the hold-window counter (HOLD_CYC is 0..255)
//   idx_w() : width of a requester index for a given requester count
// ----------------------------------------------------------------------------
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int HOLD_W = 8;

  // Requester index width; clamped to 1 so a degenerate count still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational circular priority picker. Searches req_i starting at
// ptr_i+1 and wrapping, returning the first set bit.
//   req_i   [N_REQ-1:0] : request vector
//   ptr_i   [IDX_W-1:0] : index of the last winner (search starts after it)
//   found_o             : at least one request is set
//   idx_o   [IDX_W-1:0] : winning index (0 when found_o is low)
// ----------------------------------------------------------------------------
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = (int'(ptr_i) + off) % N_REQ;
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// ----------------------------------------------------------------------------
// rr_reg_arbiter
// Round-robin arbiter sharing one DATA_W-bit holding register between N_REQ
// requesters. IDLE picks a winner, WRITE issues a one-cycle grant and writes
// the winner's data, HOLD enforces HOLD_CYC idle cycles before the next grant.
//   clk, rst      : clock, synchronous active-high reset
//   req   [N]     : per-requester request, held until gnt
//   wdata [N*W]   : per-requester data, slice i = wdata[i*DATA_W +: DATA_W]
//   lock  [N]     : (RR_ARB_LOCK_EN only) keep ownership after this write
//   gnt   [N]     : registered one-hot grant, one cycle wide
//   q     [W]     : shared register contents
//   q_valid       : q written at least once since reset
//   owner         : index of the last successful writer
//   busy          : high while in WRITE or HOLD
// Optional feature macro: RR_ARB_LOCK_EN (ownership lock port and re-entry).
// ----------------------------------------------------------------------------
module rr_reg_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
`ifdef RR_ARB_LOCK_EN
  input  logic [N_REQ-1:0]         lock,
`endif
  output logic [N_REQ-1:0]         gnt,
  output logic [DATA_W-1:0]        q,
  output logic                     q_valid,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam logic [HOLD_W-1:0] HOLD_INIT =
    (HOLD_CYC == 0) ? '0 : HOLD_W'(HOLD_CYC - 1);

  state_t              state_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    win_q;
  logic [IDX_W-1:0]    owner_q;
  logic [HOLD_W-1:0]   cnt_q;
  logic [N_REQ-1:0]    gnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                busy_q;
`ifdef RR_ARB_LOCK_EN
  logic                lock_q;
`endif

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [DATA_W-1:0]   slice [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign slice[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      win_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RR_ARB_LOCK_EN
      lock_q  <= 1'b0;
`endif
    end else begin
      gnt_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            win_q   <= pick_idx;
            state_q <= WRITE;
            busy_q  <= 1'b1;
          end
        end

        WRITE: begin
          if (req[win_q]) begin
            gnt_q   <= N_REQ'(1) << win_q;
            data_q  <= slice[win_q];
            valid_q <= 1'b1;
            owner_q <= win_q;
            ptr_q   <= win_q;
`ifdef RR_ARB_LOCK_EN
            lock_q  <= lock[win_q];
`endif
            if (HOLD_CYC == 0) begin
`ifdef RR_ARB_LOCK_EN
              // No hold window: a locking writer whose req is high right now
              // re-enters WRITE immediately.
              if (lock[win_q]) begin
                state_q <= WRITE;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
`else
              state_q <= IDLE;
              busy_q  <= 1'b0;
`endif
            end else begin
              state_q <= HOLD;
              cnt_q   <= HOLD_INIT;
            end
          end else begin
            // Winner withdrew: abandon without touching the pointer.
            state_q <= IDLE;
            busy_q  <= 1'b0;
`ifdef RR_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
          end
        end

        HOLD: begin
          if (cnt_q == '0) begin
`ifdef RR_ARB_LOCK_EN
            if (lock_q && req[owner_q]) begin
              win_q   <= owner_q;
              state_q <= WRITE;
            end else begin
              lock_q  <= 1'b0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
`else
            state_q <= IDLE;
            busy_q  <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q - HOLD_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_valid = valid_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_reg_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level reference model (pending winner, remaining
// quiet cycles, modular round-robin search).
// ----------------------------------------------------------------------------
module tb_rr_reg_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int HOLD = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    lock;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   q;
  logic            q_valid;
  logic [1:0]      owner;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int           m_due;     // winner whose write is attempted next edge, -1 none
  int           m_quiet;   // hold cycles still to elapse
  int           m_ptr;
  bit           m_locked;
  logic [N-1:0] m_gnt;
  logic [DW-1:0] m_q;
  logic         m_valid;
  int           m_owner;

  rr_reg_arbiter #(
    .N_REQ    (N),
    .DATA_W   (DW),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
`ifdef RR_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .q       (q),
    .q_valid (q_valid),
    .owner   (owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rr_search(input logic [N-1:0] r, input int last);
    for (int off = 1; off <= N; off++) begin
      if (r[(last + off) % N]) return (last + off) % N;
    end
    return -1;
  endfunction

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_due = -1; m_quiet = 0; m_ptr = N - 1; m_locked = 0;
      m_gnt = '0; m_q = '0; m_valid = 1'b0; m_owner = 0;
      return;
    end
    m_gnt = '0;
    if (m_due >= 0) begin
      if (req[m_due]) begin
        m_gnt    = N'(1) << m_due;
        m_q      = wdata[m_due*DW +: DW];
        m_valid  = 1'b1;
        m_owner  = m_due;
        m_ptr    = m_due;
        m_locked = lock[m_due];
        m_quiet  = HOLD;
        if (m_quiet > 0 || !m_locked) m_due = -1;
      end else begin
        m_due    = -1;
        m_locked = 0;
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
      if (m_quiet == 0) begin
        if (m_locked && req[m_owner]) m_due = m_owner;
        else m_locked = 0;
      end
    end else begin
      m_due = rr_search(req, m_ptr);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(m_gnt));
    // q is compared outside the grant cycle itself.
    if (m_gnt == '0) chk("q", 32'(q), 32'(m_q));
    chk("q_valid", 32'(q_valid), 32'(m_valid));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("busy", 32'(busy), 32'((m_due >= 0) || (m_quiet > 0)));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int lat, bcnt, first, ng;
    int gi_q[$];
    int gt_q[$];
    logic [DW-1:0] gd_q[$];
    bit   prev_g;
    int   exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] exp_dat[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    rst = 1'b1; req = '0; wdata = '0; lock = '0;
    m_due = -1; m_quiet = 0; m_ptr = N - 1; m_locked = 0;
    m_gnt = '0; m_q = '0; m_valid = 1'b0; m_owner = 0;

    // Reset then idle
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("idle_q", 32'(q), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // Single request: latency and busy length
    req = 4'b0001; wdata[7:0] = 8'hA5;
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (gnt[0] && lat < 0) begin lat = k; req[0] = 1'b0; end
      if (busy) bcnt++;
    end
    chk("single_latency", 32'(lat), 32'd2);
    chk("single_busy_len", 32'(bcnt), 32'd3);
    chk("single_q", 32'(q), 32'hA5);
    chk("single_owner", 32'(owner), 32'd0);
    chk("single_valid", 32'(q_valid), 32'd1);

    // All four held: order 0,1,2,3,0 every 4 cycles
    do_reset();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    prev_g = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (prev_g) gd_q.push_back(q);
      prev_g = (gnt != '0);
      if (gnt != '0) begin gi_q.push_back(oh2i(gnt)); gt_q.push_back(k); end
    end
    chk("all4_ngrants", 32'(gi_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < gi_q.size(); i++) begin
      chk("all4_order", 32'(gi_q[i]), 32'(exp_ord[i]));
      if (i < gd_q.size()) chk("all4_data", 32'(gd_q[i]), 32'(exp_dat[i]));
      if (i > 0) chk("all4_spacing", 32'(gt_q[i] - gt_q[i-1]), 32'd4);
    end
    req = '0;
    for (int k = 0; k < 4; k++) tick();

    // Requester 1 withdraws during WRITE
    req = 4'b0010; wdata[15:8] = 8'h77;
    tick();
    req = '0;
    tick();
    chk("drop_gnt", 32'(gnt), 32'h0);
    chk("drop_q", 32'(q), 32'h11);
    tick(); tick();
    req = 4'b0011;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (gnt != '0 && first < 0) first = oh2i(gnt);
      req = req & ~gnt;
    end
    chk("drop_next_first", 32'(first), 32'd1);
    req = '0;
    for (int k = 0; k < 4; k++) tick();

    // Reset during WRITE for requester 2
    req = 4'b0100; wdata[23:16] = 8'h5A;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstw_q", 32'(q), 32'h0);
    chk("rstw_gnt", 32'(gnt), 32'h0);
    chk("rstw_busy", 32'(busy), 32'h0);
    req = 4'b0101;
    first = -1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (gnt != '0 && first < 0) first = oh2i(gnt);
      req = req & ~gnt;
    end
    chk("rstw_first", 32'(first), 32'd0);
    req = '0;
    for (int k = 0; k < 4; k++) tick();

`ifdef RR_ARB_LOCK_EN
    // Ownership lock: 1,1,1 then 3
    do_reset();
    gi_q.delete();
    req = 4'b1010; lock = 4'b0010;
    ng = 0;
    for (int k = 0; k < 40 && gi_q.size() < 4; k++) begin
      tick();
      if (gnt != '0) begin
        gi_q.push_back(oh2i(gnt));
        ng++;
        if (ng == 2) lock = '0;
      end
    end
    chk("lock_ngrants", 32'(gi_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < gi_q.size(); i++)
      chk("lock_order", 32'(gi_q[i]), (i < 3) ? 32'd1 : 32'd3);
    req = '0; lock = '0;
    for (int k = 0; k < 6; k++) tick();
`endif

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          req[i] = $urandom_range(0, 1);
        end else if (req[i] && $urandom_range(0, 31) == 0) begin
          req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          wdata[i*DW +: DW] = DW'($urandom);
        end
      end
`ifdef RR_ARB_LOCK_EN
      lock = N'($urandom);
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
